sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Arbitrates the single SDRAM command core between the SD-card loader (write path, 8-word bursts of photo data) and the VGA fetch engine (read path, 8-word bursts feeding the line buffer). It also schedules periodic auto-refresh. The block sits between the two requesters and the SDRAM command/sequencing core. It issues one burst or refresh at a time and reports grant and completion back to the winning requester.

## Interface
- ADDR_W, 22, burst address width {ba[1:0], row[11:0], col[7:0]}; col[2:0] must be 0 from requesters
- REFRESH_CYCLES, 390, clk cycles between refresh requests (15.6 us at 25 MHz)
- STARVE_MAX, 4, consecutive read grants allowed while a write is pending

- clk  in  1  system clock, 25 MHz
- rst  in  1  asynchronous, active-high reset
- init_done  in  1  SDRAM power-up init complete; level
- rd_req  in  1  VGA burst read request; level, held until rd_ack
- rd_addr  in  ADDR_W  read burst start address; stable while rd_req=1
- rd_ack  out  1  one-cycle grant pulse
- rd_done  out  1  one-cycle pulse, read burst finished
- wr_req  in  1  SD loader burst write request; level, held until wr_ack
- wr_addr  in  ADDR_W  write burst start address
- wr_ack  out  1  one-cycle grant pulse
- wr_done  out  1  one-cycle pulse, write burst finished
- core_cmd  out  2  00 none, 01 write, 10 read, 11 auto-refresh
- core_addr  out  ADDR_W  latched burst address (0 for refresh)
- core_start  out  1  one-cycle pulse launching core_cmd
- core_done  in  1  one-cycle pulse from core, operation finished

## Operation
- States: INIT, IDLE, ISSUE, BUSY.
- INIT: waits for init_done=1, then goes to IDLE. Requests are ignored in INIT.
- IDLE: selects a candidate, highest priority first:
  1. Refresh, if ref_owed>0.
  2. Write, if wr_req=1 and starve_cnt==STARVE_MAX.
  3. Read, if rd_req=1.
  4. Write, if wr_req=1.
- If a candidate exists, IDLE latches cmd and address and moves to ISSUE. With no candidate it stays in IDLE.
- ISSUE lasts one cycle and drives three things:
  - core_start=1 with core_cmd/core_addr valid.
  - The matching rd_ack or wr_ack =1 (no ack for refresh).
  - A refresh grant decrements ref_owed.
- BUSY: holds core_cmd/core_addr. On core_done=1 it goes to IDLE and pulses rd_done/wr_done in the next cycle (a registered copy of core_done qualified by cmd).
- core_done outside BUSY is ignored.
- Starvation counter starve_cnt (0..STARVE_MAX):
  - +1 on each read grant while wr_req=1.
  - Cleared on every write grant.
  - Cleared on a read grant while wr_req=0.
- Refresh timer:
  - Counts 0..REFRESH_CYCLES-1 whenever init_done=1; it is held at 0 in INIT.
  - Wraps on terminal count, and each wrap increments ref_owed (2 bits, saturating at 3).
  - A wrap and a refresh grant in the same cycle leave ref_owed unchanged.
- init_done falling after INIT is ignored.

## Timing
- Reset values, all asserted asynchronously:
  - state=INIT.
  - All pulses 0.
  - core_cmd=00, core_addr=0.
  - starve_cnt=0, ref_owed=0, timer=0.
- Request-to-grant latency: a request sampled in IDLE at edge N gives ack/core_start high during cycle N+1.
- Minimum grant-to-grant spacing: 3 cycles (ISSUE, BUSY with immediate core_done, IDLE).
- A requester must drop req in the cycle after its ack. A req still high in IDLE is treated as a new request.
- Simultaneous rd_req and wr_req in IDLE follow the priority list; the loser stays pending with no ack.
- A refresh wrap during BUSY is only counted; refresh is issued at the next IDLE.
- Reset mid-BUSY aborts tracking: no done pulse is generated, and a later core_done is ignored because state is INIT.

## Test plan
- Power-up gating: rst pulse, init_done=0, wr_req=1 for 50 cycles -> no core_start. Then init_done=1 -> wr_ack and core_start with core_cmd=01 within 3 cycles, and core_addr=wr_addr.
- Arbitration: in IDLE, rd_req and wr_req rise together with rd_addr=0x000108, wr_addr=0x200000 -> read issued first (core_cmd=10, addr 0x000108). After core_done, the write is issued (01, 0x200000), and rd_done/wr_done pulse once each.
- Starvation: rd_req re-asserted continuously and wr_req held, core_done 2 cycles after each start -> exactly 4 read grants, then 1 write grant, then reads resume and starve_cnt returns to 0.
- Refresh: REFRESH_CYCLES=16, rd_req held -> core_cmd=11 issued within 3 cycles of each timer wrap, with no rd_ack in that grant.
- Refresh backlog: REFRESH_CYCLES=16, core_done withheld for 40 cycles -> after done, two back-to-back refresh grants occur before any pending read.
- Reset mid-operation: rst asserted while in BUSY, then core_done pulsed -> no rd_done/wr_done, all outputs 0, and the block waits for init_done again.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Arbitrates the SDRAM command core between the VGA read path, the SD-card
// write path and periodic auto-refresh, one burst or refresh at a time.
module sdram_port_arbiter #(
    parameter int ADDR_W         = 22,
    parameter int REFRESH_CYCLES = 390,
    parameter int STARVE_MAX     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_ack,
    output logic              wr_done,
    output logic [1:0]        core_cmd,
    output logic [ADDR_W-1:0] core_addr,
    output logic              core_start,
    input  logic              core_done
);

    localparam int TMR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;
    localparam logic [1:0] CMD_REF  = 2'b11;

    typedef enum logic [1:0] {INIT, IDLE, ISSUE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [STV_W-1:0]  starve_cnt;
    logic [1:0]        ref_owed;
    logic [TMR_W-1:0]  timer;
    logic              rd_done_q, wr_done_q;
    logic              tmr_wrap, ref_grant, rd_grant, wr_grant, starve_full;

    // Two-bit refresh debt, saturating at 3; a wrap and a grant together cancel.
    function automatic logic [1:0] owed_next(input logic [1:0] cur,
                                             input logic inc, input logic dec);
        logic [1:0] res;
        res = cur;
        if (inc && !dec && cur != 2'd3)
            res = cur + 2'd1;
        else if (dec && !inc && cur != 2'd0)
            res = cur - 2'd1;
        return res;
    endfunction

    function automatic logic [STV_W-1:0] starve_inc(input logic [STV_W-1:0] cur);
        logic [STV_W-1:0] res;
        res = cur;
        if (cur != STV_W'(STARVE_MAX))
            res = cur + STV_W'(1);
        return res;
    endfunction

    assign tmr_wrap    = (state_q != INIT) && (timer == TMR_W'(REFRESH_CYCLES - 1));
    assign ref_grant   = (state_q == ISSUE) && (cmd_q == CMD_REF);
    assign rd_grant    = (state_q == ISSUE) && (cmd_q == CMD_RD);
    assign wr_grant    = (state_q == ISSUE) && (cmd_q == CMD_WR);
    assign starve_full = (starve_cnt == STV_W'(STARVE_MAX));

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        unique case (state_q)
            INIT: begin
                if (init_done)
                    state_d = IDLE;
            end
            IDLE: begin
                if (ref_owed != 2'd0) begin
                    cmd_d   = CMD_REF;
                    addr_d  = '0;
                    state_d = ISSUE;
                end else if (wr_req && starve_full) begin
                    cmd_d   = CMD_WR;
                    addr_d  = wr_addr;
                    state_d = ISSUE;
                end else if (rd_req) begin
                    cmd_d   = CMD_RD;
                    addr_d  = rd_addr;
                    state_d = ISSUE;
                end else if (wr_req) begin
                    cmd_d   = CMD_WR;
                    addr_d  = wr_addr;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (core_done) begin
                    state_d = IDLE;
                    cmd_d   = CMD_NONE;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = INIT;
                cmd_d   = CMD_NONE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cmd_q   <= CMD_NONE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
        end
    end

    // Done pulses are a registered copy of core_done, qualified by the running command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            rd_done_q <= (state_q == BUSY) && core_done && (cmd_q == CMD_RD);
            wr_done_q <= (state_q == BUSY) && core_done && (cmd_q == CMD_WR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (wr_grant) begin
            starve_cnt <= '0;
        end else if (rd_grant) begin
            starve_cnt <= wr_req ? starve_inc(starve_cnt) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer    <= '0;
            ref_owed <= 2'd0;
        end else begin
            if (state_q == INIT || tmr_wrap)
                timer <= '0;
            else
                timer <= timer + TMR_W'(1);
            ref_owed <= owed_next(ref_owed, tmr_wrap, ref_grant);
        end
    end

    assign core_start = (state_q == ISSUE);
    assign rd_ack     = rd_grant;
    assign wr_ack     = wr_grant;
    assign rd_done    = rd_done_q;
    assign wr_done    = wr_done_q;
    assign core_cmd   = cmd_q;
    assign core_addr  = addr_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: one instance with the default refresh
// period for arbitration, one with a 16-cycle period for refresh scheduling.
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    int          n_assert = 0;
    int          n_fail = 0;

    logic        a_rst, a_init, a_rd_req, a_wr_req, a_core_done;
    logic [21:0] a_rd_addr, a_wr_addr;
    logic        a_rd_ack, a_rd_done, a_wr_ack, a_wr_done, a_core_start;
    logic [1:0]  a_core_cmd;
    logic [21:0] a_core_addr;

    logic        b_rst, b_init, b_rd_req, b_wr_req, b_core_done;
    logic [21:0] b_rd_addr, b_wr_addr;
    logic        b_rd_ack, b_rd_done, b_wr_ack, b_wr_done, b_core_start;
    logic [1:0]  b_core_cmd;
    logic [21:0] b_core_addr;

    int          cyc, mt, last_wrap, ref_seen, starts, acks;
    bit          seen;
    logic [1:0]  exp_cmd [7] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2};

    always #20 clk = ~clk;

    sdram_port_arbiter #(.ADDR_W(22), .REFRESH_CYCLES(390), .STARVE_MAX(4)) a_dut (
        .clk(clk), .rst(a_rst), .init_done(a_init),
        .rd_req(a_rd_req), .rd_addr(a_rd_addr), .rd_ack(a_rd_ack), .rd_done(a_rd_done),
        .wr_req(a_wr_req), .wr_addr(a_wr_addr), .wr_ack(a_wr_ack), .wr_done(a_wr_done),
        .core_cmd(a_core_cmd), .core_addr(a_core_addr), .core_start(a_core_start),
        .core_done(a_core_done)
    );

    sdram_port_arbiter #(.ADDR_W(22), .REFRESH_CYCLES(16), .STARVE_MAX(4)) b_dut (
        .clk(clk), .rst(b_rst), .init_done(b_init),
        .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_ack(b_rd_ack), .rd_done(b_rd_done),
        .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_ack(b_wr_ack), .wr_done(b_wr_done),
        .core_cmd(b_core_cmd), .core_addr(b_core_addr), .core_start(b_core_start),
        .core_done(b_core_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_wait_start(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_core_start) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Called in the ISSUE cycle: one BUSY cycle, then core_done for one cycle.
    task automatic a_complete();
        @(negedge clk);
        a_core_done = 1'b1;
        @(negedge clk);
        a_core_done = 1'b0;
    endtask

    // Model of the 16-cycle refresh timer of instance b, one step per negedge.
    task automatic b_tick();
        @(negedge clk);
        cyc++;
        mt++;
        if (mt == 16) begin
            mt = 0;
            last_wrap = cyc;
        end
    endtask

    task automatic b_wait_start(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            b_tick();
            if (b_core_start) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        a_rst = 1'b1; a_init = 1'b0; a_rd_req = 1'b0; a_wr_req = 1'b0; a_core_done = 1'b0;
        a_rd_addr = '0; a_wr_addr = '0;
        b_rst = 1'b1; b_init = 1'b0; b_rd_req = 1'b0; b_wr_req = 1'b0; b_core_done = 1'b0;
        b_rd_addr = '0; b_wr_addr = '0;
        cyc = 0; mt = -1; last_wrap = -100; ref_seen = 0;
        repeat (2) @(negedge clk);

        chk("reset_ctrl", {a_core_cmd, a_core_start, a_rd_ack, a_wr_ack, a_rd_done, a_wr_done}, 0);
        chk("reset_addr", a_core_addr, 0);

        // Power-up gating
        a_rst = 1'b0; b_rst = 1'b0;
        a_wr_req = 1'b1; a_wr_addr = 22'h123400;
        starts = 0; acks = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            starts += int'(a_core_start);
            acks   += int'(a_wr_ack | a_rd_ack);
        end
        chk("init_gate_start", starts, 0);
        chk("init_gate_ack", acks, 0);
        a_init = 1'b1;
        a_wait_start(3, seen);
        chk("init_start_seen", seen, 1);
        chk("init_wr_ack", {a_wr_ack, a_rd_ack}, 2'b10);
        chk("init_cmd", a_core_cmd, 2'b01);
        chk("init_addr", a_core_addr, 22'h123400);
        a_wr_req = 1'b0;
        @(negedge clk);
        chk("busy_hold", {a_core_cmd, a_core_start, a_wr_ack}, {2'b01, 1'b0, 1'b0});
        a_core_done = 1'b1;
        @(negedge clk);
        a_core_done = 1'b0;
        chk("init_wr_done", {a_wr_done, a_rd_done, a_core_cmd}, {1'b1, 1'b0, 2'b00});
        @(negedge clk);
        chk("init_done_pulse_end", a_wr_done, 0);

        // Simultaneous requests: read wins, write follows
        a_rd_req = 1'b1; a_rd_addr = 22'h000108;
        a_wr_req = 1'b1; a_wr_addr = 22'h200000;
        a_wait_start(3, seen);
        chk("arb_rd_seen", seen, 1);
        chk("arb_rd_cmd", a_core_cmd, 2'b10);
        chk("arb_rd_addr", a_core_addr, 22'h000108);
        chk("arb_rd_ack", {a_rd_ack, a_wr_ack}, 2'b10);
        a_rd_req = 1'b0;
        @(negedge clk);
        chk("arb_loser_no_ack", {a_wr_ack, a_core_cmd}, {1'b0, 2'b10});
        a_core_done = 1'b1;
        @(negedge clk);
        a_core_done = 1'b0;
        chk("arb_rd_done", {a_rd_done, a_wr_done}, 2'b10);
        a_wait_start(3, seen);
        chk("arb_wr_seen", seen, 1);
        chk("arb_wr_cmd", a_core_cmd, 2'b01);
        chk("arb_wr_addr", a_core_addr, 22'h200000);
        chk("arb_wr_ack", {a_rd_ack, a_wr_ack}, 2'b01);
        a_wr_req = 1'b0;
        a_complete();
        chk("arb_wr_done", {a_rd_done, a_wr_done}, 2'b01);
        @(negedge clk);
        chk("arb_done_once", {a_rd_done, a_wr_done}, 2'b00);

        // Starvation: four reads, one write, then reads again
        a_rd_req = 1'b1; a_wr_req = 1'b1;
        for (int g = 0; g < 7; g++) begin
            a_wait_start(4, seen);
            chk("starve_seen", seen, 1);
            chk($sformatf("starve_cmd%0d", g), a_core_cmd, exp_cmd[g]);
            chk($sformatf("starve_ack%0d", g), {a_rd_ack, a_wr_ack}, exp_cmd[g]);
            if (exp_cmd[g] == 2'd1)
                a_wr_req = 1'b0;
            @(negedge clk);
            @(negedge clk);
            a_core_done = 1'b1;
            @(negedge clk);
            a_core_done = 1'b0;
        end
        a_rd_req = 1'b0;
        chk("starve_cnt_cleared", a_dut.starve_cnt, 0);

        // Reset while BUSY, then a stray core_done
        a_rd_req = 1'b1; a_rd_addr = 22'h000200;
        a_wait_start(3, seen);
        chk("rst_rd_seen", seen, 1);
        a_rd_req = 1'b0;
        @(negedge clk);
        chk("rst_busy_cmd", a_core_cmd, 2'b10);
        a_rst = 1'b1; a_init = 1'b0;
        #1;
        chk("rst_async_ctrl", {a_core_cmd, a_core_start, a_rd_ack, a_wr_ack, a_rd_done, a_wr_done}, 0);
        chk("rst_async_addr", a_core_addr, 0);
        @(negedge clk);
        a_rst = 1'b0;
        @(negedge clk);
        a_core_done = 1'b1;
        @(negedge clk);
        a_core_done = 1'b0;
        chk("rst_no_done", {a_rd_done, a_wr_done, a_core_cmd, a_core_start}, 0);
        a_rd_req = 1'b1;
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            starts += int'(a_core_start);
        end
        chk("rst_waits_init", starts, 0);
        a_init = 1'b1;
        a_wait_start(3, seen);
        chk("rst_regrant_seen", seen, 1);
        chk("rst_regrant", {a_core_cmd, a_core_addr}, {2'b10, 22'h000200});
        a_rd_req = 1'b0;
        a_complete();
        chk("rst_regrant_done", a_rd_done, 1);

        // Refresh every 16 cycles while reads are streaming
        b_rd_req = 1'b1; b_rd_addr = 22'h000308; b_core_done = 1'b1; b_init = 1'b1;
        for (int i = 0; i < 70; i++) begin
            b_tick();
            if (b_core_start && b_core_cmd == 2'b11) begin
                ref_seen++;
                chk("ref_latency", int'((cyc - last_wrap) >= 1 && (cyc - last_wrap) <= 3), 1);
                chk("ref_no_rd_ack", b_rd_ack, 0);
            end
        end
        chk("ref_count", ref_seen, 4);

        // Refresh backlog built up while a read is held in BUSY
        b_rd_req = 1'b0;
        repeat (8) b_tick();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            b_tick();
            if (mt == 0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("backlog_wrap_found", seen, 1);
        repeat (3) b_tick();
        b_rd_req = 1'b1; b_core_done = 1'b0;
        b_wait_start(3, seen);
        chk("backlog_rd_seen", seen, 1);
        chk("backlog_rd_cmd", b_core_cmd, 2'b10);
        repeat (40) b_tick();
        b_core_done = 1'b1;
        b_tick();
        chk("backlog_rd_done", b_rd_done, 1);
        for (int k = 0; k < 2; k++) begin
            b_wait_start(4, seen);
            chk("backlog_ref_seen", seen, 1);
            chk($sformatf("backlog_ref%0d", k), {b_core_cmd, b_rd_ack}, {2'b11, 1'b0});
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            b_tick();
            if (b_core_start && b_core_cmd == 2'b10) begin
                seen = 1'b1;
                break;
            end
        end
        chk("backlog_rd_resumes", {seen, b_rd_ack}, 2'b11);
        b_rd_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
